mult_4bit_seq: RTL and testbench
================================

MULT_4BIT_SEQ -- requirements
Module: mult_4bit_seq

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: multiplicand  input  WIDTH  operand A; captured on start acceptance.
REQ-006 Port: multiplier  input  WIDTH  operand B; captured on start acceptance.
REQ-007 Port: product  output  2*WIDTH  registered result A*B, unsigned.
REQ-008 Port: busy  output  1  high while in CALC.
REQ-009 Port: done  output  1  one-cycle pulse; product valid from this cycle.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-011 IDLE -> CALC SHALL occur on a rising edge with start=1, capturing both operands, clearing the accumulator and setting the step counter to 0.
REQ-012 CALC SHALL perform one shift-add step per cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; increment the counter.
REQ-013 CALC -> DONE SHALL occur on the edge completing step WIDTH; the accumulator SHALL be written to product on that edge.
REQ-014 DONE -> IDLE SHALL occur unconditionally on the next edge; done is high for exactly one cycle.
REQ-015 Latency SHALL be fixed: done is high in the cycle after the WIDTH-th edge following acceptance (5 cycles from acceptance edge for WIDTH=4), independent of operand values, including zero operands.
REQ-016 start SHALL be ignored in CALC and DONE; operand input changes after acceptance SHALL not affect the result.
REQ-017 start held high continuously SHALL launch a new operation in each IDLE cycle (back-to-back: one IDLE cycle between done and the next busy).
REQ-018 product SHALL hold its last value through IDLE and the next CALC, and SHALL change only on entering DONE.
REQ-019 The accumulator SHALL be 2*WIDTH bits; no overflow is possible ((2^WIDTH-1)^2 fits).
REQ-020 busy and done SHALL never both be high; busy=1 exactly in CALC, done=1 exactly in DONE.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, product=0, busy=0, done=0, counter=0, and SHALL clear internal operand registers, regardless of clock.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start normally.
REQ-023 The first start SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-024 A shared package mult_pkg SHALL hold the state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-025 The block SHALL be a single flat module; no sub-module is required (FSM and datapath in one file, 120-200 lines).
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-027 A=5, B=2, start pulse -> busy for 4 cycles, then done=1 for 1 cycle with product=10.
REQ-028 A=15, B=15 -> product=225 at done, with latency identical to REQ-027.
REQ-029 A=0, B=9, then A=9, B=0 -> product=0 each time, with full 4-cycle busy and a done pulse.
REQ-030 start held high, operands changed mid-CALC (A=3, B=5, then 7, 1) -> first done gives 15, second gives 7, with one IDLE cycle between operations.
REQ-031 rst pulsed during CALC step 2 of A=6, B=6 -> outputs go to 0 immediately with no done; next start with A=6, B=6 -> product=36.
REQ-032 start asserted during DONE -> ignored; product stays unchanged until an IDLE start is given.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings
// and the default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_4bit_seq.sv
// Unsigned sequential multiplier: one shift-add step per clock in CALC,
// result registered on the final step and flagged by a one-cycle done pulse.
module mult_4bit_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier;
  logic               last_step;

  // Partial product for the current step; also the final result on the last step.
  assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
  assign last_step = (count == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, multiplicand};
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // product only moves here, so it holds through IDLE and the next CALC
          if (last_step) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mult_4bit_seq.sv
// Scoreboard bench for mult_4bit_seq: the driver pushes A*B and the acceptance
// edge, a negedge monitor checks busy/done timing and the product.
module tb_mult_4bit_seq;
  import mult_pkg::*;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  typedef struct {
    int prod;
    int acc_edge;
    int a;
    int b;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   last_prod  = 0;

  mult_4bit_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Expected timing: accepted on edge n, busy after edges n..n+W-1,
  // done after edge n+W; product otherwise holds its last value.
  always @(negedge clk) begin : monitor
    int k;
    int eb;
    int ed;
    k  = cyc;
    eb = 0;
    ed = 0;
    if (sb.size() > 0) begin
      eb = (k >= sb[0].acc_edge && k < sb[0].acc_edge + W) ? 1 : 0;
      ed = (k == sb[0].acc_edge + W) ? 1 : 0;
    end
    check("busy", int'(busy), eb);
    check("done", int'(done), ed);
    if (ed == 1) begin
      check("product", int'(product), sb[0].prod);
      $display("txn: A=%0d B=%0d product=%0d expected=%0d", sb[0].a, sb[0].b, product, sb[0].prod);
      last_prod = sb[0].prod;
      void'(sb.pop_front());
    end else begin
      check("product_hold", int'(product), last_prod);
    end
  end

  task automatic push_exp(input int a, input int b);
    exp_t e;
    e.prod     = a * b;
    e.acc_edge = cyc;
    e.a        = a;
    e.b        = b;
    sb.push_back(e);
  endtask

  // One operation from IDLE; returns just after the DONE->IDLE edge.
  // poke=1 raises start during the DONE cycle, which must be ignored.
  task automatic issue(input int a, input int b, input bit poke);
    @(negedge clk);
    multiplicand = W'(a);
    multiplier   = W'(b);
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(a, b);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    repeat (W) @(posedge clk);
    #1;
    if (poke) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    rst          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1 rst = 1'b1;
    #1;
    check("reset_product", int'(product), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed operand patterns, including zeros and the maximum
    issue(5, 2, 1'b0);
    issue(15, 15, 1'b0);
    issue(0, 9, 1'b0);
    issue(9, 0, 1'b0);

    // start held high with operands changed mid-CALC
    @(negedge clk);
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(3, 5);
    n = cyc;
    @(posedge clk);
    #1;
    multiplicand = 4'd7;
    multiplier   = 4'd1;
    while (cyc < n + W + 2) begin
      @(posedge clk);
      #1;
    end
    push_exp(7, 1);
    start = 1'b0;
    repeat (W + 1) @(posedge clk);
    #1;

    // Asynchronous reset during CALC step 2 of 6*6
    @(negedge clk);
    multiplicand = 4'd6;
    multiplier   = 4'd6;
    start        = 1'b1;
    @(posedge clk);
    #1;
    push_exp(6, 6);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_product", int'(product), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    sb.delete();
    last_prod = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(6, 6, 1'b0);

    // start during DONE is ignored; product must then hold
    issue(4, 3, 1'b1);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
